// File: rtl/avalon_st_rr_arbiter_pkg.sv
// Shared types and the circular priority search used by the Avalon-ST round-robin arbiter.
package avalon_st_arb_pkg;

  localparam int MAX_IN = 16;
  localparam int MAX_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // First set bit of req at or after ptr, wrapping at n; returns 0 when req is empty.
  function automatic logic [MAX_W-1:0] next_rr(input logic [MAX_IN-1:0] req,
                                               input logic [MAX_W-1:0]  ptr,
                                               input int                n);
    logic [MAX_W-1:0] idx;
    next_rr = '0;
    for (int k = MAX_IN - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = MAX_W'((int'(ptr) + k) % n);
        if (req[idx]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/avalon_st_rr_arbiter_if.sv
// Bundle of NUM_IN Avalon-ST sources plus the single shared Avalon-ST output.
interface avalon_st_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32
);
  import avalon_st_arb_pkg::*;

  localparam int CH_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_sop;
  logic [NUM_IN-1:0]            in_eop;
  logic [NUM_IN-1:0]            in_ready;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_sop;
  logic                         out_eop;
  logic [CH_W-1:0]              out_channel;
  logic                         out_ready;

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_channel
  );

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_channel
  );

endinterface

// File: rtl/avalon_st_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer.
module avalon_st_rr_arbiter_rr_pick
  import avalon_st_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_found
);

  assign o_idx   = IDX_W'(next_rr(MAX_IN'(i_req), MAX_W'(i_ptr), NUM_IN));
  assign o_found = |i_req;

endmodule

// File: rtl/avalon_st_rr_arbiter.sv
// Packet-aware round-robin arbiter: holds a grant from sop to eop, rotates priority
// after each packet and drops a stalled grant through an idle watchdog.
module avalon_st_rr_arbiter
  import avalon_st_arb_pkg::*;
#(
  parameter int NUM_IN       = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  avalon_st_rr_arbiter_if.slave bus,
  output logic                  err_timeout,
  output logic                  err_no_sop
);

  localparam int GW    = $clog2(NUM_IN);
  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  state_e            r_state;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_ptr;
  logic [CNT_W-1:0]  r_idle_cnt;
  logic              r_first;
  logic              r_err_timeout;
  logic              r_err_no_sop;

  logic [GW-1:0]         w_pick;
  logic                  w_found;
  logic                  w_locked;
  logic                  w_gvalid;
  logic                  w_gsop;
  logic                  w_geop;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_accept;
  logic                  w_expire;
  logic [GW-1:0]         w_next_ptr;

  avalon_st_rr_arbiter_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .i_req   (bus.in_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  // Select the granted source; unused sources see ready low.
  always_comb begin
    w_gvalid = 1'b0;
    w_gsop   = 1'b0;
    w_geop   = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == GW'(i)) begin
        w_gvalid = bus.in_valid[i];
        w_gsop   = bus.in_sop[i];
        w_geop   = bus.in_eop[i];
        w_gdata  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_locked   = (r_state == LOCKED);
  assign w_accept   = w_locked && w_gvalid && bus.out_ready;
  assign w_expire   = (IDLE_TIMEOUT != 0) && w_locked && !w_gvalid &&
                      (r_idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));
  assign w_next_ptr = (r_grant == GW'(NUM_IN - 1)) ? '0 : r_grant + 1'b1;

  assign bus.out_valid   = w_locked && w_gvalid;
  assign bus.out_data    = w_locked ? w_gdata : '0;
  assign bus.out_sop     = w_locked && w_gsop;
  assign bus.out_eop     = w_locked && w_geop;
  assign bus.out_channel = r_grant;
  assign bus.in_ready    = w_locked ? (NUM_IN'(bus.out_ready) << r_grant) : '0;

  assign err_timeout = r_err_timeout;
  assign err_no_sop  = r_err_no_sop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_ptr         <= '0;
      r_idle_cnt    <= '0;
      r_first       <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_no_sop  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant    <= w_pick;
            r_state    <= LOCKED;
            r_first    <= 1'b1;
            r_idle_cnt <= '0;
          end
        end
        LOCKED: begin
          // Only a source that has nothing to offer counts as idle; backpressure does not.
          if (w_gvalid)
            r_idle_cnt <= '0;
          else if (IDLE_TIMEOUT != 0)
            r_idle_cnt <= r_idle_cnt + 1'b1;
          if (w_accept) begin
            r_first <= 1'b0;
            if (r_first && !w_gsop) r_err_no_sop <= 1'b1;
            if (w_geop) begin
              r_ptr   <= w_next_ptr;
              r_state <= IDLE;
            end
          end
          // Expiry needs in_valid low, so it never collides with an eop acceptance.
          if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_ptr         <= w_next_ptr;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Directed bench for avalon_st_rr_arbiter with a per-cycle reference model and literal checks.
module tb_avalon_st_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_timeout, err_no_sop;

  always #5 clk = ~clk;

  avalon_st_rr_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW)) bus ();

  avalon_st_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .err_timeout (err_timeout),
    .err_no_sop  (err_no_sop)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  beat_t srcq[N][$];
  int    sop_ch[$];
  int    beat_ch[$];
  int    beat_cyc[$];
  int    exp_q[$];
  logic [N-1:0] acc;

  // Reference model: packet-level arbitration state.
  bit m_locked, m_first, m_err_to, m_err_ns;
  int m_grant, m_ptr, m_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_seq(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, act[i], exp[i]);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += srcq[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        bus.in_valid[i] = 1'b1;
        bus.in_data[i*DW +: DW] = srcq[i][0].data;
        bus.in_sop[i] = srcq[i][0].sop;
        bus.in_eop[i] = srcq[i][0].eop;
      end else begin
        bus.in_valid[i] = 1'b0;
        bus.in_data[i*DW +: DW] = '0;
        bus.in_sop[i] = 1'b0;
        bus.in_eop[i] = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int src, input int len, input int tag, input bit first_sop);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {8'hA5, 8'(src), 8'(tag), 8'(k)};
      b.sop  = (k == 0) ? first_sop : 1'b0;
      b.eop  = (k == len - 1);
      srcq[src].push_back(b);
    end
  endtask

  task automatic clear_logs();
    sop_ch.delete();
    beat_ch.delete();
    beat_cyc.delete();
  endtask

  task automatic model_cycle();
    logic          e_valid, e_sop, e_eop;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_ready;
    int            g;
    bit            found;
    if (!rst_n) begin
      m_locked = 0; m_first = 0; m_err_to = 0; m_err_ns = 0;
      m_grant = 0; m_ptr = 0; m_idle = 0;
    end
    g = m_grant;
    e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_data = '0; e_ready = '0;
    if (m_locked) begin
      e_valid    = bus.in_valid[g];
      e_sop      = bus.in_sop[g];
      e_eop      = bus.in_eop[g];
      e_data     = bus.in_data[g*DW +: DW];
      e_ready[g] = bus.out_ready;
    end
    chk("ctrl", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_channel, bus.in_ready},
                {e_valid, e_sop, e_eop, 2'(g), e_ready});
    chk("data", bus.out_data, e_data);
    chk("err", {err_timeout, err_no_sop}, {m_err_to, m_err_ns});
    if (rst_n) begin
      if (!m_locked) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && bus.in_valid[(m_ptr + k) % N]) begin
            found   = 1;
            m_grant = (m_ptr + k) % N;
          end
        end
        if (found) begin
          m_locked = 1; m_first = 1; m_idle = 0;
        end
      end else if (bus.in_valid[g]) begin
        m_idle = 0;
        if (bus.out_ready) begin
          if (m_first && !bus.in_sop[g]) m_err_ns = 1;
          m_first = 0;
          if (bus.in_eop[g]) begin
            m_ptr = (g + 1) % N;
            m_locked = 0;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_err_to = 1;
          m_ptr = (g + 1) % N;
          m_locked = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      beat_ch.push_back(int'(bus.out_channel));
      beat_cyc.push_back(cyc);
      if (bus.out_sop) sop_ch.push_back(int'(bus.out_channel));
    end
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic run_drain(input string name, input int max_cyc, input bit toggle);
    int n = 0;
    while (pending() > 0 && n < max_cyc) begin
      if (toggle) bus.out_ready = !bus.out_ready;
      tick();
      n++;
    end
    chk({name, "_drained"}, pending(), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int min_gap;
    bus.out_ready = 1'b0;
    drive();
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_channel", bus.out_channel, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Two sources, two 3-beat packets each, alternating grants with one bubble.
    clear_logs();
    for (int p = 0; p < 2; p++) begin
      push_pkt(0, 3, p, 1'b1);
      push_pkt(2, 3, p, 1'b1);
    end
    drive();
    run_drain("t1", 100, 1'b0);
    exp_q = '{0, 2, 0, 2};
    chk_seq("t1_sop_order", sop_ch, exp_q);
    exp_q = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};
    chk_seq("t1_beat_order", beat_ch, exp_q);
    chk("t1_span", (beat_cyc.size() == 12) ? beat_cyc[11] - beat_cyc[0] : -1, 14);

    // All four request together after reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_logs();
    push_pkt(0, 2, 0, 1'b1);
    push_pkt(0, 2, 1, 1'b1);
    push_pkt(1, 2, 0, 1'b1);
    push_pkt(2, 2, 0, 1'b1);
    push_pkt(3, 2, 0, 1'b1);
    drive();
    run_drain("t2", 100, 1'b0);
    exp_q = '{0, 1, 2, 3, 0};
    chk_seq("t2_sop_order", sop_ch, exp_q);

    // Single-beat packets under alternating backpressure.
    clear_logs();
    for (int k = 0; k < 3; k++) push_pkt(1, 1, k, 1'b1);
    drive();
    run_drain("t3", 100, 1'b1);
    bus.out_ready = 1'b1;
    exp_q = '{1, 1, 1};
    chk_seq("t3_sop", sop_ch, exp_q);
    chk_seq("t3_beats", beat_ch, exp_q);
    min_gap = 1000;
    for (int k = 1; k < beat_cyc.size(); k++)
      if (beat_cyc[k] - beat_cyc[k-1] < min_gap) min_gap = beat_cyc[k] - beat_cyc[k-1];
    chk("t3_release_gap", (min_gap >= 2), 1);

    // Source 3 stalls after sop; watchdog must release it.
    clear_logs();
    push_pkt(3, 2, 0, 1'b1);
    void'(srcq[3].pop_back());
    drive();
    n = 0;
    while (srcq[3].size() > 0 && n < 50) begin tick(); n++; end
    chk("t4_sop_taken", srcq[3].size(), 0);
    clear_logs();
    push_pkt(0, 2, 7, 1'b1);
    drive();
    n = 0;
    while (!err_timeout && n < 200) begin tick(); n++; end
    chk("t4_timeout_cycles", n, TO);
    run_drain("t4", 50, 1'b0);
    exp_q = '{0};
    chk_seq("t4_next_grant", sop_ch, exp_q);
    chk("t4_err_sticky", err_timeout, 1);

    // Missing sop on first beat.
    push_pkt(0, 2, 8, 1'b0);
    drive();
    run_drain("t5a", 50, 1'b0);
    chk("t5_no_sop_set", err_no_sop, 1);
    push_pkt(0, 2, 9, 1'b1);
    drive();
    run_drain("t5b", 50, 1'b0);
    chk("t5_no_sop_sticky", err_no_sop, 1);

    // Reset in the middle of a source 2 packet.
    push_pkt(2, 4, 0, 1'b1);
    drive();
    n = 0;
    while (srcq[2].size() > 2 && n < 50) begin tick(); n++; end
    chk("t6_midpkt", srcq[2].size(), 2);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    #1;
    chk("t6_rst_out", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data}, 0);
    chk("t6_rst_ready", bus.in_ready, 0);
    chk("t6_rst_channel", bus.out_channel, 0);
    chk("t6_rst_err", {err_timeout, err_no_sop}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    push_pkt(1, 1, 0, 1'b1);
    push_pkt(2, 1, 0, 1'b1);
    drive();
    run_drain("t6", 50, 1'b0);
    exp_q = '{1, 2};
    chk_seq("t6_after_reset", sop_ch, exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
